// File: rtl/booth_multiplier_seq_if.sv
// Operand, control and result bundle for the radix-4 Booth multiplier.
interface booth_multiplier_seq_if #(
  parameter int WIDTH = 64
);
  logic                   op_start;
  logic                   op_clear;
  logic                   signed_mode;
  logic [WIDTH-1:0]       multiplier;
  logic [WIDTH-1:0]       multiplicand;
  logic                   busy;
  logic                   op_done;
  logic [2*WIDTH-1:0]     result;

  modport master (
    output op_start, op_clear, signed_mode, multiplier, multiplicand,
    input  busy, op_done, result
  );

  modport slave (
    input  op_start, op_clear, signed_mode, multiplier, multiplicand,
    output busy, op_done, result
  );
endinterface

// File: rtl/booth_multiplier_seq.sv
// Iterative radix-4 Booth multiplier, two multiplier bits retired per cycle.
// Product is ready (WIDTH+2)/2 edges after op_start; held in DONE until op_clear.
module booth_multiplier_seq #(
  parameter int WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  booth_multiplier_seq_if.slave bus
);
  localparam int N  = (WIDTH + 2) / 2;
  localparam int CW = (N > 2) ? $clog2(N) : 2;
  localparam int HW = WIDTH + 4;
  localparam int AW = HW + WIDTH + 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [HW-1:0]      r_mcand;
  logic [AW-1:0]      r_acc;
  logic [2*WIDTH-1:0] r_result;

  logic [HW-1:0]      w_mcand_ext;
  logic [WIDTH+1:0]   w_mplr_ext;
  logic [HW-1:0]      w_pp;
  logic [HW-1:0]      w_sum;
  logic [AW-1:0]      w_acc_nxt;

  // r_acc = {partial product (HW), multiplier (WIDTH+2), implicit 0}; the
  // extra headroom in the upper part keeps the signed add from overflowing.
  always_comb begin
    w_mcand_ext = {{4{bus.signed_mode & bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
    w_mplr_ext  = {{2{bus.signed_mode & bus.multiplier[WIDTH-1]}}, bus.multiplier};
    w_pp        = '0;
    case (r_acc[2:0])
      3'b001, 3'b010: w_pp = r_mcand;
      3'b011:         w_pp = {r_mcand[HW-2:0], 1'b0};
      3'b100:         w_pp = {HW{1'b0}} - {r_mcand[HW-2:0], 1'b0};
      3'b101, 3'b110: w_pp = {HW{1'b0}} - r_mcand;
      default:        w_pp = '0;
    endcase
    w_sum     = r_acc[AW-1:WIDTH+3] + w_pp;
    w_acc_nxt = {{2{w_sum[HW-1]}}, w_sum, r_acc[WIDTH+2:2]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else if (bus.op_clear) begin
      r_state  <= S_IDLE;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.op_start) begin
            r_mcand <= w_mcand_ext;
            r_acc   <= {{HW{1'b0}}, w_mplr_ext, 1'b0};
            r_cnt   <= CW'(N - 1);
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_acc <= w_acc_nxt;
          if (r_cnt == '0) begin
            // Product sits one bit above the implicit-zero position.
            r_result <= w_acc_nxt[2*WIDTH:1];
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = (r_state == S_EXEC);
  assign bus.op_done = (r_state == S_DONE);
  assign bus.result  = r_result;
endmodule
